mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle main control FSM for the single-issue MIPS-subset datapath.
- Sequences fetch, decode, execute, memory and writeback over several clocks.
- Supported instructions: R-type (opcode 0), j (2), beq (4), lw (35), sw (43). The ALU control decoder downstream consumes aluop.
- Stalls on a memory ready handshake. Traps on illegal opcodes. Counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter
TRAP_ON_ILLEGAL, 1, 1 = illegal opcode enters TRAP; 0 = treated as NOP and returns to FETCH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr  input  32  current instruction register contents; only [31:26] used
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
mem_read  output  1  memory read request
mem_write  output  1  memory write request
iord  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
ir_write  output  1  load instruction register
pc_en  output  1  PC write enable
pc_source  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
alu_src_a  output  1  0 = PC, 1 = register A
alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
aluop  output  2  00 add, 01 sub, 10 funct-decoded
reg_dst  output  1  1 = rd, 0 = rt
mem_to_reg  output  1  1 = MDR, 0 = ALUOut
reg_write  output  1  register file write enable
illegal  output  1  sticky illegal-opcode flag
state  output  4  current state encoding (debug)
instr_count  output  CNT_W  retired instruction count

Behaviour:
- State encoding:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
  - EXEC=7, RTWB=8, BRANCH=9, JUMP=10, TRAP=11
- Reset (rst_n low, asynchronous):
  - state=IDLE, opcode_q=0, illegal=0, instr_count=0.
  - All control outputs 0 while in IDLE.
  - IDLE to FETCH unconditionally on the first clock after rst_n deasserts.
- Outputs are Moore decodes of state, except the mem_ready-qualified enables listed below.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_source=00.
  - ir_write=mem_ready, pc_en=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, aluop=00 (precompute branch target).
  - opcode_q <= instr[31:26].
  - Next state: 35/43 -> MEMADR, 0 -> EXEC, 4 -> BRANCH, 2 -> JUMP.
  - Any other opcode -> TRAP if TRAP_ON_ILLEGAL=1, else FETCH with instr_count+1.
- MEMADR:
  - alu_src_a=1, alu_src_b=10, aluop=00.
  - Next state: MEMRD if opcode_q=35, else MEMWR.
- MEMRD:
  - mem_read=1, iord=1.
  - Wait for mem_ready, then go to MEMWB.
- MEMWB:
  - reg_write=1, mem_to_reg=1, reg_dst=0.
  - Go to FETCH; instr_count+1.
- MEMWR:
  - mem_write=1, iord=1.
  - Wait for mem_ready, then go to FETCH with instr_count+1.
  - mem_write holds high continuously until the mem_ready cycle.
- EXEC:
  - alu_src_a=1, alu_src_b=00, aluop=10.
  - Go to RTWB.
- RTWB:
  - reg_write=1, reg_dst=1, mem_to_reg=0.
  - Go to FETCH; instr_count+1.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, aluop=01, pc_source=01, pc_en=zero.
  - Go to FETCH; instr_count+1 whether or not the branch is taken.
- JUMP:
  - pc_source=10, pc_en=1.
  - Go to FETCH; instr_count+1.
- TRAP:
  - illegal=1 (set on entry, sticky); all other control outputs 0.
  - Remains in TRAP until reset.
- Latency with mem_ready tied high:
  - R-type 4 cycles, lw 5, sw 4, beq 3, j 3 (FETCH to FETCH).
  - Each mem_ready=0 cycle adds one stall cycle.
- instr_count wraps from 2^CNT_W-1 to 0 with no flag.
- instr changing after DECODE has no effect; only opcode_q steers later states.
- reg_write and mem_write are never asserted in the same cycle. ir_write is asserted only in FETCH.
- Reset asserted mid-instruction: all outputs drop to 0 immediately (asynchronously). No partial write or PC update completes.

Test Plan:
- Reset, release rst_n, mem_ready=1, instr opcode 0 -> IDLE,FETCH,DECODE,EXEC,RTWB,FETCH. reg_write=1 and reg_dst=1 only in RTWB. instr_count=1.
- lw (opcode 35) with mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles with iord=1, mem_read=1. MEMWB asserts reg_write=1, mem_to_reg=1. Total 7 cycles.
- beq (opcode 4) with zero=1, then zero=0 -> pc_en=1 with pc_source=01 in BRANCH for the first, pc_en=0 for the second. instr_count increments by 2.
- j (opcode 2) then sw (opcode 43) -> JUMP asserts pc_en=1, pc_source=10. MEMWR asserts mem_write=1, iord=1 until mem_ready. reg_write stays 0 throughout.
- Opcode 63, TRAP_ON_ILLEGAL=1 -> TRAP, illegal=1, state=11, held 20 cycles regardless of mem_ready. rst_n low clears illegal asynchronously.
- CNT_W=4, 16 R-type instructions -> instr_count wraps 15 to 0. Assert rst_n low during MEMWR -> mem_write drops before the next clock edge.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main control FSM for the MIPS-subset datapath.
// Walks fetch/decode/execute/memory/writeback over several clocks, stalls on
// the memory ready handshake, traps on unknown opcodes and counts retirements.
// Moore controls are registered alongside the state (decoded from the next
// state), so they line up with state and fall to zero the moment rst_n drops.
// Only the handshake-qualified enables (ir_write, fetch/branch pc_en) are
// combined combinationally with mem_ready / zero.

module mc_ctrl_fsm #(
    parameter int CNT_W           = 16,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       aluop,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        st_idle   = 4'd0,
        st_fetch  = 4'd1,
        st_decode = 4'd2,
        st_memadr = 4'd3,
        st_memrd  = 4'd4,
        st_memwb  = 4'd5,
        st_memwr  = 4'd6,
        st_exec   = 4'd7,
        st_rtwb   = 4'd8,
        st_branch = 4'd9,
        st_jump   = 4'd10,
        st_trap   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // Pure Moore controls; pc_en_jmp covers the unconditional JUMP PC write.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       pc_en_jmp;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctl_t;

    state_t     state_r;
    state_t     next_state_s;
    ctl_t       ctl_r;
    logic [5:0] opcode_q;
    logic       illegal_r;
    logic       retire_s;
    logic [CNT_W-1:0] count_r;
    logic       unused_s;

    function automatic ctl_t moore_decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            st_fetch: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            st_decode: c.alu_src_b = 2'b11;
            st_memadr: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            st_memrd: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            st_memwb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            st_memwr: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            st_exec: begin
                c.alu_src_a = 1'b1;
                c.aluop     = 2'b10;
            end
            st_rtwb: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            st_branch: begin
                c.alu_src_a = 1'b1;
                c.aluop     = 2'b01;
                c.pc_source = 2'b01;
            end
            st_jump: begin
                c.pc_source = 2'b10;
                c.pc_en_jmp = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection and retirement strobe.
    always_comb begin
        next_state_s = state_r;
        retire_s     = 1'b0;
        case (state_r)
            st_idle: next_state_s = st_fetch;
            st_fetch: begin
                if (mem_ready) begin
                    next_state_s = st_decode;
                end else begin
                    next_state_s = st_fetch;
                end
            end
            st_decode: begin
                case (instr[31:26])
                    OP_LW, OP_SW: next_state_s = st_memadr;
                    OP_RTYPE:     next_state_s = st_exec;
                    OP_BEQ:       next_state_s = st_branch;
                    OP_J:         next_state_s = st_jump;
                    default: begin
                        if (TRAP_ON_ILLEGAL) begin
                            next_state_s = st_trap;
                        end else begin
                            next_state_s = st_fetch;
                            retire_s     = 1'b1;
                        end
                    end
                endcase
            end
            st_memadr: begin
                if (opcode_q == OP_LW) begin
                    next_state_s = st_memrd;
                end else begin
                    next_state_s = st_memwr;
                end
            end
            st_memrd: begin
                if (mem_ready) begin
                    next_state_s = st_memwb;
                end else begin
                    next_state_s = st_memrd;
                end
            end
            st_memwr: begin
                if (mem_ready) begin
                    next_state_s = st_fetch;
                    retire_s     = 1'b1;
                end else begin
                    next_state_s = st_memwr;
                end
            end
            st_exec: next_state_s = st_rtwb;
            st_memwb, st_rtwb, st_branch, st_jump: begin
                next_state_s = st_fetch;
                retire_s     = 1'b1;
            end
            st_trap: next_state_s = st_trap;
            default: next_state_s = st_idle;
        endcase
    end

    // State, registered Moore controls, latched opcode, sticky trap flag, retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= st_idle;
            ctl_r     <= '0;
            opcode_q  <= 6'd0;
            illegal_r <= 1'b0;
            count_r   <= '0;
        end else begin
            state_r   <= next_state_s;
            ctl_r     <= moore_decode(next_state_s);
            illegal_r <= illegal_r | (next_state_s == st_trap);
            if (state_r == st_decode) begin
                opcode_q <= instr[31:26];
            end
            if (retire_s) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Only the opcode field steers control; the rest of the word is the datapath's.
    assign unused_s = ^instr[25:0];

    assign mem_read    = ctl_r.mem_read;
    assign mem_write   = ctl_r.mem_write;
    assign iord        = ctl_r.iord;
    assign ir_write    = (state_r == st_fetch) & mem_ready;
    assign pc_en       = ctl_r.pc_en_jmp
                       | ((state_r == st_fetch) & mem_ready)
                       | ((state_r == st_branch) & zero);
    assign pc_source   = ctl_r.pc_source;
    assign alu_src_a   = ctl_r.alu_src_a;
    assign alu_src_b   = ctl_r.alu_src_b;
    assign aluop       = ctl_r.aluop;
    assign reg_dst     = ctl_r.reg_dst;
    assign mem_to_reg  = ctl_r.mem_to_reg;
    assign reg_write   = ctl_r.reg_write;
    assign illegal     = illegal_r;
    assign state       = state_r;
    assign instr_count = count_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm (CNT_W=4 so the counter wrap is reachable).
// A vector table drives the main instruction mix; hand-written sequences cover
// trap, counter wrap and asynchronous reset during a memory write.

module tb_mc_ctrl_fsm;

    localparam int CNT_W = 4;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_RTWB   = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_TRAP   = 4'd11;

    logic             clk;
    logic             rst_n;
    logic [31:0]      instr;
    logic             zero;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_en;
    logic [1:0]       pc_source;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       aluop;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;
    logic [14:0]      act_ctl;

    mc_ctrl_fsm #(.CNT_W(CNT_W), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_en(pc_en), .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .aluop(aluop), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal(illegal), .state(state), .instr_count(instr_count)
    );

    assign act_ctl = {mem_read, mem_write, iord, ir_write, pc_en, pc_source,
                      alu_src_a, alu_src_b, aluop, reg_dst, mem_to_reg, reg_write};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic       mr;
        logic       z;
        logic [3:0] st;
        logic [3:0] cnt;
        logic       ill;
    } vec_t;

    typedef struct {
        logic [3:0]  st;
        logic [14:0] ctl;
        logic [3:0]  cnt;
        logic        ill;
        int          tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   tag_n    = 0;

    // Control word the datapath should see in a given state, from the state table.
    function automatic logic [14:0] ctl_model(input logic [3:0] st, input logic mr, input logic z);
        logic mrd, mwr, io, irw, pce, asa, rd, m2r, rw;
        logic [1:0] psrc, asb, aop;
        {mrd, mwr, io, irw, pce, asa, rd, m2r, rw} = 9'd0;
        psrc = 2'b00; asb = 2'b00; aop = 2'b00;
        case (st)
            S_FETCH:  begin mrd = 1'b1; irw = mr; pce = mr; asb = 2'b01; end
            S_DECODE: asb = 2'b11;
            S_MEMADR: begin asa = 1'b1; asb = 2'b10; end
            S_MEMRD:  begin mrd = 1'b1; io = 1'b1; end
            S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
            S_MEMWR:  begin mwr = 1'b1; io = 1'b1; end
            S_EXEC:   begin asa = 1'b1; aop = 2'b10; end
            S_RTWB:   begin rw = 1'b1; rd = 1'b1; end
            S_BRANCH: begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pce = z; end
            S_JUMP:   begin psrc = 2'b10; pce = 1'b1; end
            default:  ;
        endcase
        return {mrd, mwr, io, irw, pce, psrc, asa, asb, aop, rd, m2r, rw};
    endfunction

    function automatic void add(input logic [5:0] op, input logic mr, input logic z,
                                input logic [3:0] st, input logic [3:0] cnt, input logic ill);
        vec_t v;
        v.op = op; v.mr = mr; v.z = z; v.st = st; v.cnt = cnt; v.ill = ill;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h expected=%0h", name, tag, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("state", e.tag, {28'd0, state}, {28'd0, e.st});
            chk("ctl", e.tag, {17'd0, act_ctl}, {17'd0, e.ctl});
            chk("instr_count", e.tag, {28'd0, instr_count}, {28'd0, e.cnt});
            chk("illegal", e.tag, {31'd0, illegal}, {31'd0, e.ill});
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        @(negedge clk);
        instr     = {v.op, 26'($urandom)};
        mem_ready = v.mr;
        zero      = v.z;
        e.st = v.st; e.ctl = ctl_model(v.st, v.mr, v.z); e.cnt = v.cnt; e.ill = v.ill;
        e.tag = tag_n;
        tag_n++;
        sb.push_back(e);
        #2;
        check_out();
    endtask

    task automatic drv(input logic [5:0] op, input logic mr, input logic z,
                       input logic [3:0] st, input logic [3:0] cnt, input logic ill);
        vec_t v;
        v.op = op; v.mr = mr; v.z = z; v.st = st; v.cnt = cnt; v.ill = ill;
        drive(v);
    endtask

    // Release reset on a falling edge; the FSM must still sit in IDLE with outputs clear.
    task automatic release_rst();
        exp_t e;
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b1;
        e.st = S_IDLE; e.ctl = ctl_model(S_IDLE, 1'b1, 1'b1); e.cnt = 4'd0; e.ill = 1'b0;
        e.tag = tag_n;
        tag_n++;
        sb.push_back(e);
        #2;
        check_out();
    endtask

    task automatic check_reset_now(input string name);
        chk({name, "_state"}, tag_n, {28'd0, state}, 32'd0);
        chk({name, "_ctl"}, tag_n, {17'd0, act_ctl}, 32'd0);
        chk({name, "_count"}, tag_n, {28'd0, instr_count}, 32'd0);
        chk({name, "_illegal"}, tag_n, {31'd0, illegal}, 32'd0);
    endtask

    initial begin
        // R-type with mem_ready high
        add(6'd0,  1'b1, 1'b1, S_FETCH,  4'd0, 1'b0);
        add(6'd0,  1'b1, 1'b1, S_DECODE, 4'd0, 1'b0);
        add(6'd0,  1'b1, 1'b1, S_EXEC,   4'd0, 1'b0);
        add(6'd0,  1'b1, 1'b1, S_RTWB,   4'd0, 1'b0);
        // lw, instr changes after DECODE, two stall cycles in MEMRD
        add(6'd35, 1'b1, 1'b1, S_FETCH,  4'd1, 1'b0);
        add(6'd35, 1'b1, 1'b1, S_DECODE, 4'd1, 1'b0);
        add(6'd43, 1'b1, 1'b1, S_MEMADR, 4'd1, 1'b0);
        add(6'd43, 1'b0, 1'b1, S_MEMRD,  4'd1, 1'b0);
        add(6'd43, 1'b0, 1'b1, S_MEMRD,  4'd1, 1'b0);
        add(6'd43, 1'b1, 1'b1, S_MEMRD,  4'd1, 1'b0);
        add(6'd0,  1'b1, 1'b1, S_MEMWB,  4'd1, 1'b0);
        // beq taken, then not taken
        add(6'd4,  1'b1, 1'b1, S_FETCH,  4'd2, 1'b0);
        add(6'd4,  1'b1, 1'b1, S_DECODE, 4'd2, 1'b0);
        add(6'd4,  1'b1, 1'b1, S_BRANCH, 4'd2, 1'b0);
        add(6'd4,  1'b1, 1'b0, S_FETCH,  4'd3, 1'b0);
        add(6'd4,  1'b1, 1'b0, S_DECODE, 4'd3, 1'b0);
        add(6'd4,  1'b1, 1'b0, S_BRANCH, 4'd3, 1'b0);
        // j
        add(6'd2,  1'b1, 1'b1, S_FETCH,  4'd4, 1'b0);
        add(6'd2,  1'b1, 1'b1, S_DECODE, 4'd4, 1'b0);
        add(6'd2,  1'b1, 1'b1, S_JUMP,   4'd4, 1'b0);
        // sw, instr flips to lw after DECODE, two stall cycles in MEMWR
        add(6'd43, 1'b1, 1'b1, S_FETCH,  4'd5, 1'b0);
        add(6'd43, 1'b1, 1'b1, S_DECODE, 4'd5, 1'b0);
        add(6'd35, 1'b1, 1'b1, S_MEMADR, 4'd5, 1'b0);
        add(6'd35, 1'b0, 1'b1, S_MEMWR,  4'd5, 1'b0);
        add(6'd35, 1'b0, 1'b1, S_MEMWR,  4'd5, 1'b0);
        add(6'd35, 1'b1, 1'b1, S_MEMWR,  4'd5, 1'b0);
        // fetch stall, then R-type with instr changing in EXEC
        add(6'd0,  1'b0, 1'b1, S_FETCH,  4'd6, 1'b0);
        add(6'd0,  1'b0, 1'b1, S_FETCH,  4'd6, 1'b0);
        add(6'd0,  1'b1, 1'b1, S_FETCH,  4'd6, 1'b0);
        add(6'd0,  1'b1, 1'b1, S_DECODE, 4'd6, 1'b0);
        add(6'd4,  1'b1, 1'b1, S_EXEC,   4'd6, 1'b0);
        add(6'd4,  1'b1, 1'b1, S_RTWB,   4'd6, 1'b0);
        add(6'd0,  1'b1, 1'b1, S_FETCH,  4'd7, 1'b0);

        rst_n     = 1'b0;
        instr     = 32'd0;
        mem_ready = 1'b1;
        zero      = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check_reset_now("reset");
        release_rst();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
        end

        // Illegal opcode: trap, sticky, immune to mem_ready
        drv(6'd63, 1'b1, 1'b1, S_DECODE, 4'd7, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drv(6'($urandom), 1'($urandom), 1'($urandom), S_TRAP, 4'd7, 1'b1);
        end
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_now("trap_async_rst");
        @(negedge clk);
        release_rst();

        // 16 R-type instructions wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            drv(6'd0, 1'b1, 1'b1, S_FETCH,  4'(i), 1'b0);
            drv(6'd0, 1'b1, 1'b1, S_DECODE, 4'(i), 1'b0);
            drv(6'd0, 1'b1, 1'b1, S_EXEC,   4'(i), 1'b0);
            drv(6'd0, 1'b1, 1'b1, S_RTWB,   4'(i), 1'b0);
        end
        drv(6'd43, 1'b1, 1'b1, S_FETCH, 4'd0, 1'b0);

        // Reset in the middle of a stalled store
        drv(6'd43, 1'b1, 1'b1, S_DECODE, 4'd0, 1'b0);
        drv(6'd43, 1'b1, 1'b1, S_MEMADR, 4'd0, 1'b0);
        drv(6'd43, 1'b0, 1'b1, S_MEMWR,  4'd0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_now("memwr_async_rst");
        @(negedge clk);
        release_rst();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
